// File: rtl/mindfocus_core.sv
// Memory-sequence game core: the player repeats a stored sequence of button targets.
// It counts hits, misses and per-move timeouts, and it can end on the first miss (sudden death).
module mindfocus_core #(
   parameter int N_BOTOES       = 4,
   parameter int PROF           = 16,
   parameter int TIMEOUT_CICLOS = 5000,
   localparam int WB = $clog2(N_BOTOES),
   localparam int WE = $clog2(PROF),
   localparam int WC = $clog2(PROF + 1),
   localparam int WT = $clog2(TIMEOUT_CICLOS)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                iniciar,
   input  logic                modo,
   input  logic [WC-1:0]       limite,
   input  logic [N_BOTOES-1:0] botoes,
   input  logic                escreve,
   input  logic [WE-1:0]       endereco,
   input  logic [WB-1:0]       dado,
   output logic                pronto,
   output logic                jogando,
   output logic [WB-1:0]       alvo,
   output logic [WC-1:0]       acertos,
   output logic [WC-1:0]       erros,
   output logic [WE-1:0]       indice,
   output logic                timeout,
   output logic [3:0]          db_estado
);

   typedef enum logic [3:0] {
      INICIAL = 4'd0,
      PREPARA = 4'd1,
      ESPERA  = 4'd2,
      AVALIA  = 4'd3,
      PROXIMA = 4'd4,
      FIM     = 4'd5
   } estado_t;

   estado_t       estado_q;
   logic          pronto_q, jogando_q, timeout_q, modo_q, acerto_q, qualquer_q;
   logic [WC-1:0] acertos_q, erros_q, lim_q, lim_d;
   logic [WE-1:0] indice_q;
   logic [WT-1:0] timer_q;
   logic [WB-1:0] idx_d;
   logic          acerto_d, press_d, ultimo_d;

   logic [WB-1:0] memoria [PROF];

   // Sequence memory is deliberately outside the reset domain so its contents survive reset.
   always_ff @(posedge clock) begin
      if (escreve && (estado_q == INICIAL || estado_q == FIM) && (32'(endereco) < PROF))
         memoria[endereco] <= dado;
   end

   assign alvo = memoria[indice_q];

   always_comb begin
      idx_d = '0;
      for (int i = 0; i < N_BOTOES; i++)
         if (botoes[i]) idx_d = WB'(i);
   end

   assign acerto_d = $onehot(botoes) && (idx_d == alvo);
   assign press_d  = (|botoes) && !qualquer_q;
   assign ultimo_d = (WC'(indice_q) == lim_q - WC'(1));

   always_comb begin
      lim_d = limite;
      if (limite == '0 || 32'(limite) > PROF) lim_d = WC'(PROF);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q   <= INICIAL;
         pronto_q   <= 1'b0;
         jogando_q  <= 1'b0;
         timeout_q  <= 1'b0;
         modo_q     <= 1'b0;
         acerto_q   <= 1'b0;
         qualquer_q <= 1'b0;
         acertos_q  <= '0;
         erros_q    <= '0;
         lim_q      <= '0;
         indice_q   <= '0;
         timer_q    <= '0;
      end else begin
         qualquer_q <= |botoes;
         pronto_q   <= 1'b0;
         case (estado_q)
            INICIAL, FIM: begin
               if (iniciar) begin
                  estado_q  <= PREPARA;
                  jogando_q <= 1'b1;
               end
            end
            PREPARA: begin
               acertos_q <= '0;
               erros_q   <= '0;
               indice_q  <= '0;
               timeout_q <= 1'b0;
               modo_q    <= modo;
               lim_q     <= lim_d;
               timer_q   <= '0;
               estado_q  <= ESPERA;
            end
            ESPERA: begin
               // A press arriving on the expiry cycle still counts as a real move.
               if (press_d) begin
                  acerto_q <= acerto_d;
                  estado_q <= AVALIA;
               end else if (timer_q == WT'(TIMEOUT_CICLOS - 1)) begin
                  acerto_q  <= 1'b0;
                  timeout_q <= 1'b1;
                  estado_q  <= AVALIA;
               end else begin
                  timer_q <= timer_q + WT'(1);
               end
            end
            AVALIA: begin
               if (acerto_q) acertos_q <= acertos_q + WC'(1);
               else          erros_q   <= erros_q + WC'(1);
               estado_q <= PROXIMA;
            end
            PROXIMA: begin
               if (ultimo_d || (modo_q && !acerto_q)) begin
                  estado_q  <= FIM;
                  pronto_q  <= 1'b1;
                  jogando_q <= 1'b0;
               end else begin
                  indice_q <= indice_q + WE'(1);
                  timer_q  <= '0;
                  estado_q <= ESPERA;
               end
            end
            default: begin
               estado_q  <= INICIAL;
               jogando_q <= 1'b0;
            end
         endcase
      end
   end

   assign pronto    = pronto_q;
   assign jogando   = jogando_q;
   assign acertos   = acertos_q;
   assign erros     = erros_q;
   assign indice    = indice_q;
   assign timeout   = timeout_q;
   assign db_estado = estado_q;

endmodule

// File: tb/tb_mindfocus_core.sv
// Directed bench for mindfocus_core: each game pushes its expected final counters;
// a monitor pops and compares them on every pronto pulse.
module tb_mindfocus_core;

   localparam int NB = 4;
   localparam int PR = 4;
   localparam int TO = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       iniciar = 1'b0;
   logic       modo = 1'b0;
   logic       escreve = 1'b0;
   logic [2:0] limite = '0;
   logic [3:0] botoes = '0;
   logic [1:0] endereco = '0;
   logic [1:0] dado = '0;

   logic       pronto, jogando, timeout;
   logic [1:0] alvo, indice;
   logic [2:0] acertos, erros;
   logic [3:0] db_estado;

   mindfocus_core #(.N_BOTOES(NB), .PROF(PR), .TIMEOUT_CICLOS(TO)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .modo(modo), .limite(limite),
      .botoes(botoes), .escreve(escreve), .endereco(endereco), .dado(dado),
      .pronto(pronto), .jogando(jogando), .alvo(alvo), .acertos(acertos), .erros(erros),
      .indice(indice), .timeout(timeout), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   typedef struct {
      int a;
      int e;
      int idx;
      int to;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   vectors = 0;
   int   miscompares = 0;
   logic pronto_prev = 1'b0;

   task automatic check(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: every pronto pulse must match the oldest outstanding game expectation.
   always @(negedge clock) begin
      if (pronto) begin
         check("pronto_width", int'(pronto_prev), 0);
         if (sb.size() == 0) begin
            check("pronto_unexpected", sb.size(), 1);
         end else begin
            cur = sb.pop_front();
            check("fim_acertos", int'(acertos), cur.a);
            check("fim_erros", int'(erros), cur.e);
            check("fim_indice", int'(indice), cur.idx);
            check("fim_timeout", int'(timeout), cur.to);
            check("fim_estado", int'(db_estado), 5);
            check("fim_jogando", int'(jogando), 0);
            $display("game done: acertos=%0d erros=%0d indice=%0d timeout=%0d",
                     acertos, erros, indice, timeout);
         end
      end
      pronto_prev <= pronto;
   end

   task automatic wait_state(input int s, input string name);
      int n = 0;
      while (int'(db_estado) != s && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (int'(db_estado) != s) check(name, int'(db_estado), s);
   endtask

   task automatic write_mem(input int a, input int d);
      endereco = 2'(a);
      dado     = 2'(d);
      escreve  = 1'b1;
      @(negedge clock);
      escreve  = 1'b0;
   endtask

   task automatic start_game(input logic m, input int lim, input int ea, input int ee,
                             input int eidx, input int eto, input logic push);
      modo    = m;
      limite  = 3'(lim);
      iniciar = 1'b1;
      if (push) sb.push_back('{ea, ee, eidx, eto});
      @(negedge clock);
      iniciar = 1'b0;
      check("prepara_estado", int'(db_estado), 1);
      check("prepara_jogando", int'(jogando), 1);
   endtask

   task automatic press(input logic [3:0] b, input int delay, input int exp_alvo, input logic hold);
      wait_state(2, "wait_espera");
      check("alvo", int'(alvo), exp_alvo);
      repeat (delay) @(negedge clock);
      botoes = b;
      @(negedge clock);
      if (!hold) botoes = '0;
      check("avalia_estado", int'(db_estado), 3);
      $display("press %b (alvo %0d, delay %0d)", b, exp_alvo, delay);
   endtask

   task automatic timeout_move(input int exp_alvo);
      int n = 0;
      wait_state(2, "wait_espera_to");
      check("alvo_to", int'(alvo), exp_alvo);
      while (int'(db_estado) == 2 && n < 50) begin
         n++;
         @(negedge clock);
      end
      check("timeout_cycles", n, TO);
      check("timeout_flag", int'(timeout), 1);
      $display("timeout move after %0d cycles", n);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clock);
      check("rst_estado", int'(db_estado), 0);
      check("rst_jogando", int'(jogando), 0);
      check("rst_pronto", int'(pronto), 0);
      check("rst_acertos", int'(acertos), 0);
      check("rst_erros", int'(erros), 0);
      check("rst_indice", int'(indice), 0);
      check("rst_timeout", int'(timeout), 0);
      reset = 1'b1;
      @(negedge clock);

      write_mem(0, 2);
      write_mem(1, 0);
      write_mem(2, 3);
      write_mem(3, 1);
      check("alvo_loaded", int'(alvo), 2);

      // Game 1: all correct.
      start_game(1'b0, 4, 4, 0, 3, 0, 1'b1);
      press(4'b0100, 0, 2, 1'b0);
      press(4'b0001, 0, 0, 1'b0);
      press(4'b1000, 0, 3, 1'b0);
      press(4'b0010, 0, 1, 1'b0);
      wait_state(5, "wait_fim1");
      repeat (3) @(negedge clock);
      check("fim_hold_acertos", int'(acertos), 4);
      check("fim_hold_estado", int'(db_estado), 5);

      // Game 2: wrong index and multi-hot; limite above depth; modo/limite changed mid-game.
      start_game(1'b0, 7, 2, 2, 3, 0, 1'b1);
      press(4'b0100, 0, 2, 1'b0);
      modo   = 1'b1;
      limite = 3'd1;
      press(4'b0010, 0, 0, 1'b0);
      press(4'b1100, 0, 3, 1'b0);
      press(4'b0010, 0, 1, 1'b0);
      wait_state(5, "wait_fim2");

      // Game 3: sudden death on the first miss.
      start_game(1'b1, 4, 0, 1, 0, 0, 1'b1);
      press(4'b0001, 0, 2, 1'b0);
      wait_state(5, "wait_fim3");

      // Game 4: timeout on move 0, then a press exactly on the expiry cycle of move 1.
      start_game(1'b0, 2, 1, 1, 1, 1, 1'b1);
      timeout_move(2);
      press(4'b0001, TO - 1, 0, 1'b0);
      wait_state(5, "wait_fim4");

      // Game 5: mid-game write attempt and asynchronous reset on move 2.
      start_game(1'b0, 4, 0, 0, 0, 0, 1'b0);
      press(4'b0100, 0, 2, 1'b0);
      press(4'b0001, 0, 0, 1'b0);
      wait_state(2, "wait_espera_m2");
      check("mid_acertos", int'(acertos), 2);
      check("mid_indice", int'(indice), 2);
      write_mem(2, 0);
      #2 reset = 1'b0;
      #1;
      check("async_estado", int'(db_estado), 0);
      check("async_acertos", int'(acertos), 0);
      check("async_indice", int'(indice), 0);
      check("async_jogando", int'(jogando), 0);
      check("async_alvo", int'(alvo), 2);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      // Game 6: limite=0 means full depth; held button counts once; memory intact.
      start_game(1'b0, 0, 3, 1, 3, 1, 1'b1);
      press(4'b0100, 0, 2, 1'b1);
      timeout_move(0);
      botoes = '0;
      press(4'b1000, 0, 3, 1'b0);
      press(4'b0010, 0, 1, 1'b0);
      wait_state(5, "wait_fim6");

      repeat (3) @(negedge clock);
      check("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
